// File: rtl/change_dispenser.sv
// change_dispenser: pays out change from three coin tubes ($5, $2, $1).
// Coins are picked greedily, one solenoid pulse at a time, with a fixed
// on-time and gap after each pulse. Any amount that cannot be paid is
// reported on short_change.
// Optional build macro: CHANGE_AUDIT_EN adds the audit_total output, a
// saturating running total of dollars dispensed since reset.
module change_dispenser #(
  parameter int TUBE_DEPTH   = 15,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  amount,
  input  logic        refill,
  output logic [2:0]  coin_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  short_change,
  output logic [3:0]  tube5_cnt,
  output logic [3:0]  tube2_cnt,
  output logic [3:0]  tube1_cnt,
  output logic        low_change
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0] audit_total
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [3:0]  DEPTH     = 4'(TUBE_DEPTH);
  localparam logic [15:0] PULSE_END = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_END   = 16'(GAP_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  rem_reg, rem_next;
  logic [2:0]  sel_reg, sel_next;
  logic [15:0] timer_reg, timer_next;
  logic [7:0]  short_reg, short_next;

  // Tube counts indexed by coin_out bit: [2]=$5, [1]=$2, [0]=$1
  logic [3:0]  cnt_reg  [3];
  logic [3:0]  cnt_next [3];

  logic [2:0]  avail;      // tube non-empty and coin fits the remainder
  logic [2:0]  low;        // tube below two coins
  logic [2:0]  take;       // one-hot coin removed from its tube this cycle
  logic [2:0]  pick;       // greedy choice among available coins
  logic [7:0]  pick_val;   // dollar value of pick
  logic        refill_go;

  // Per-tube availability, low flag and next count
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tube
      localparam logic [7:0] COIN_VAL = (gi == 2) ? 8'd5 : ((gi == 1) ? 8'd2 : 8'd1);
      assign avail[gi]    = (cnt_reg[gi] != 4'd0) && (rem_reg >= COIN_VAL);
      assign low[gi]      = (cnt_reg[gi] < 4'd2);
      assign cnt_next[gi] = refill_go ? DEPTH
                          : (take[gi] ? (cnt_reg[gi] - 4'd1) : cnt_reg[gi]);
    end
  endgenerate

  // State, remainder, selection, timer, shortfall and tube count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      rem_reg   <= 8'd0;
      sel_reg   <= 3'b000;
      timer_reg <= 16'd0;
      short_reg <= 8'd0;
      for (int i = 0; i < 3; i++) cnt_reg[i] <= DEPTH;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      sel_reg   <= sel_next;
      timer_reg <= timer_next;
      short_reg <= short_next;
      for (int i = 0; i < 3; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  // Next-state logic and FSM outputs
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    sel_next   = sel_reg;
    timer_next = timer_reg;
    short_next = short_reg;
    take       = 3'b000;
    refill_go  = 1'b0;
    pick       = 3'b000;
    pick_val   = 8'd0;
    coin_out   = 3'b000;
    busy       = (state_reg != S_IDLE);
    done       = 1'b0;

    // Greedy priority: largest coin that fits and is in stock
    if (avail[2]) begin
      pick     = 3'b100;
      pick_val = 8'd5;
    end else if (avail[1]) begin
      pick     = 3'b010;
      pick_val = 8'd2;
    end else if (avail[0]) begin
      pick     = 3'b001;
      pick_val = 8'd1;
    end

    case (state_reg)
      S_IDLE: begin
        refill_go = refill;
        if (start) begin
          rem_next   = amount;
          short_next = 8'd0;
          state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (pick != 3'b000) begin
          take       = pick;
          rem_next   = rem_reg - pick_val;
          sel_next   = pick;
          timer_next = 16'd0;
          state_next = S_PULSE;
        end else begin
          // Nothing fits (or nothing left to pay): report the remainder
          short_next = rem_reg;
          state_next = S_DONE;
        end
      end
      S_PULSE: begin
        coin_out = sel_reg;
        if (timer_reg == PULSE_END) begin
          timer_next = 16'd0;
          state_next = S_GAP;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end
      S_GAP: begin
        if (timer_reg == GAP_END) begin
          timer_next = 16'd0;
          state_next = S_SELECT;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign short_change = short_reg;
  assign tube5_cnt    = cnt_reg[2];
  assign tube2_cnt    = cnt_reg[1];
  assign tube1_cnt    = cnt_reg[0];
  assign low_change   = |low;

`ifdef CHANGE_AUDIT_EN
  logic [15:0] audit_reg;
  logic [16:0] audit_sum;

  assign audit_sum = {1'b0, audit_reg} + {9'd0, pick_val};

  // Saturating running total of dollars dispensed; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      audit_reg <= 16'd0;
    end else if (take != 3'b000) begin
      audit_reg <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
    end
  end

  assign audit_total = audit_reg;
`endif

endmodule
